// File: rtl/fofir_tap_seq.sv
// Tap sequencer for a folded FIR: walks mux_sel over 0..N-1 once per pass, honouring downstream stall.
// Optional FOFIR_TAP_SEQ_REPEAT_EN adds repeat_mode for back-to-back passes with no bubble.
module fofir_tap_seq #(
  parameter int SEL_W    = 3,
  parameter int MAX_TAPS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] num_taps,
  input  logic             stall,
`ifdef FOFIR_TAP_SEQ_REPEAT_EN
  input  logic             repeat_mode,
`endif
  output logic [SEL_W-1:0] mux_sel,
  output logic             sel_valid,
  output logic             first_tap,
  output logic             last_tap,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [SEL_W-1:0] ONE = SEL_W'(1);
  localparam logic [SEL_W-1:0] MAX = SEL_W'(MAX_TAPS);

  state_t           state;
  logic [SEL_W-1:0] cnt_lat;
  logic             rep;
  logic             cfg_ok;
  logic             at_last;
  logic [SEL_W-1:0] sel_nxt;

`ifdef FOFIR_TAP_SEQ_REPEAT_EN
  assign rep = repeat_mode;
`else
  assign rep = 1'b0;
`endif

  assign cfg_ok    = (num_taps != '0) && (num_taps <= MAX);
  assign at_last   = (mux_sel == cnt_lat - ONE);
  assign sel_nxt   = mux_sel + ONE;
  assign sel_valid = (state == RUN) && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_lat   <= '0;
      mux_sel   <= '0;
      first_tap <= 1'b0;
      last_tap  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state     <= RUN;
              cnt_lat   <= num_taps;
              mux_sel   <= '0;
              first_tap <= 1'b1;
              last_tap  <= (num_taps == ONE);
              busy      <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          // Nothing moves while stalled; flags are held with mux_sel.
          if (!stall) begin
            if (at_last) begin
              done    <= 1'b1;
              mux_sel <= '0;
              if (rep) begin
                first_tap <= 1'b1;
                last_tap  <= (cnt_lat == ONE);
              end else begin
                state     <= DONE;
                first_tap <= 1'b0;
                last_tap  <= 1'b0;
              end
            end else begin
              mux_sel   <= sel_nxt;
              first_tap <= 1'b0;
              last_tap  <= (sel_nxt == cnt_lat - ONE);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mux_sel   <= '0;
          first_tap <= 1'b0;
          last_tap  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
